// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the serial memory_interface between NCLIENTS
// requesters (fixed-priority or round-robin) and routes RX replies via a tag FIFO.
//
// Ports:
//   clk, reset (async, active low)
//   req_*               per-client command, payload, reply/reserve flags
//   grant               one-hot current TX owner
//   c_tx_* / c_rx_*     per-client copies of the memory-interface strobes
//   tx_command_valid, tx_command, tx_data   to memory_interface
//   tx_* / rx_* inputs  strobes from memory_interface
//   outstanding, full   reads awaiting a reply
//   rx_orphan           sticky: a reply arrived with no read outstanding
module mem_port_arbiter #(
  parameter int NCLIENTS        = 2,
  parameter int IO_BITS         = 2,
  parameter int CMD_BITS        = 3,
  parameter int MAX_OUTSTANDING = 7,
  parameter int RR_MODE         = 0,
  parameter int TAG_BITS        =
    (NCLIENTS > 1) ? $clog2(NCLIENTS) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NCLIENTS-1:0]          req_valid,
  input  logic [NCLIENTS*CMD_BITS-1:0] req_command,
  input  logic [NCLIENTS*IO_BITS-1:0]  req_data,
  input  logic [NCLIENTS-1:0]          req_reply_wanted,
  input  logic [NCLIENTS-1:0]          req_reserve,
  output logic [NCLIENTS-1:0]          grant,
  output logic [NCLIENTS-1:0]          c_tx_command_started,
  output logic [NCLIENTS-1:0]          c_tx_active,
  output logic [NCLIENTS-1:0]          c_tx_data_next,
  output logic [NCLIENTS-1:0]          c_tx_done,
  output logic [NCLIENTS-1:0]          c_rx_started,
  output logic [NCLIENTS-1:0]          c_rx_active,
  output logic [NCLIENTS-1:0]          c_rx_sbs_valid,
  output logic [NCLIENTS-1:0]          c_rx_data_valid,
  output logic [NCLIENTS-1:0]          c_rx_done,
  output logic                         tx_command_valid,
  output logic [CMD_BITS-1:0]          tx_command,
  output logic [IO_BITS-1:0]           tx_data,
  input  logic                         tx_command_started,
  input  logic                         tx_active,
  input  logic                         tx_data_next,
  input  logic                         tx_done,
  input  logic                         rx_started,
  input  logic                         rx_active,
  input  logic                         rx_sbs_valid,
  input  logic                         rx_data_valid,
  input  logic                         rx_done,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
  output logic                         full,
  output logic                         rx_orphan
);

  localparam int PTR_BITS =
    (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_BITS = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [PTR_BITS-1:0] PTR_LAST =
    PTR_BITS'(MAX_OUTSTANDING - 1);
  localparam logic [CNT_BITS-1:0] CNT_MAX =
    CNT_BITS'(MAX_OUTSTANDING);
  localparam logic [TAG_BITS-1:0] TAG_LAST =
    TAG_BITS'(NCLIENTS - 1);

  logic [TAG_BITS-1:0] owner_q;
  logic [TAG_BITS-1:0] rr_ptr;
  logic                reserved_q;
  logic [TAG_BITS-1:0] arb;
  logic [TAG_BITS-1:0] sel;
  logic                hold;
  logic [NCLIENTS-1:0] req_any;
  logic                sel_valid;
  logic                own_reserve;
  logic                own_reply;

  logic [TAG_BITS-1:0] fifo_q [MAX_OUTSTANDING];
  logic [PTR_BITS-1:0] head_q;
  logic [PTR_BITS-1:0] tail_q;
  logic [CNT_BITS-1:0] count_q;
  logic [TAG_BITS-1:0] head_tag;
  logic [NCLIENTS-1:0] rx_sel;
  logic                rx_ok;
  logic                push;
  logic                pop;
  logic [NCLIENTS-1:0] tx_gate;
  logic [NCLIENTS-1:0] rx_gate;

  function automatic logic [PTR_BITS-1:0] ptr_inc(
    input logic [PTR_BITS-1:0] p
  );
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign req_any = req_valid | req_reserve;
  assign hold    = tx_active | reserved_q;
  assign sel     = hold ? owner_q : arb;

  // Later loop iterations overwrite earlier ones: in fixed mode the
  // highest index wins; in RR mode the scan runs backwards from
  // rr_ptr+N-1 so the last hit is the first requester at/after rr_ptr.
  always_comb begin
    arb = owner_q;
    if (RR_MODE == 0) begin
      for (int i = 0; i < NCLIENTS; i++) begin
        if (req_any[i]) arb = TAG_BITS'(i);
      end
    end else begin
      for (int k = NCLIENTS - 1; k >= 0; k--) begin
        int idx;
        idx = (int'(rr_ptr) + k) % NCLIENTS;
        if (req_any[idx]) arb = TAG_BITS'(idx);
      end
    end
  end

  assign head_tag = fifo_q[head_q];

  always_comb begin
    grant       = '0;
    rx_sel      = '0;
    tx_command  = '0;
    tx_data     = '0;
    sel_valid   = 1'b0;
    own_reserve = 1'b0;
    own_reply   = 1'b0;
    for (int i = 0; i < NCLIENTS; i++) begin
      grant[i]  = (sel == TAG_BITS'(i));
      rx_sel[i] = (head_tag == TAG_BITS'(i));
      if (sel == TAG_BITS'(i)) begin
        tx_command = req_command[i*CMD_BITS +: CMD_BITS];
        tx_data    = req_data[i*IO_BITS +: IO_BITS];
        sel_valid  = req_valid[i];
      end
      if (owner_q == TAG_BITS'(i)) begin
        own_reserve = req_reserve[i];
        own_reply   = req_reply_wanted[i];
      end
    end
  end

  assign outstanding      = count_q;
  assign full             = (count_q == CNT_MAX);
  assign rx_ok            = (count_q != '0);
  assign tx_command_valid = sel_valid & ~full;

  // Strobes are forced low while reset is held.
  assign tx_gate = grant & {NCLIENTS{reset}};
  assign rx_gate = rx_sel & {NCLIENTS{rx_ok & reset}};

  assign c_tx_command_started = {NCLIENTS{tx_command_started}} & tx_gate;
  assign c_tx_active          = {NCLIENTS{tx_active}} & tx_gate;
  assign c_tx_data_next       = {NCLIENTS{tx_data_next}} & tx_gate;
  assign c_tx_done            = {NCLIENTS{tx_done}} & tx_gate;
  assign c_rx_started         = {NCLIENTS{rx_started}} & rx_gate;
  assign c_rx_active          = {NCLIENTS{rx_active}} & rx_gate;
  assign c_rx_sbs_valid       = {NCLIENTS{rx_sbs_valid}} & rx_gate;
  assign c_rx_data_valid      = {NCLIENTS{rx_data_valid}} & rx_gate;
  assign c_rx_done            = {NCLIENTS{rx_done}} & rx_gate;

  assign push = tx_command_started & own_reply & ~full;
  assign pop  = rx_done & rx_ok;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q    <= '0;
      rr_ptr     <= '0;
      reserved_q <= 1'b0;
    end else begin
      if (!hold) owner_q <= arb;
      if (tx_done) begin
        reserved_q <= own_reserve;
      end else if (reserved_q && !tx_active && !own_reserve) begin
        reserved_q <= 1'b0;
      end
      if (tx_done && !own_reserve) begin
        rr_ptr <= (owner_q == TAG_LAST) ? '0 : owner_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      rx_orphan <= 1'b0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) fifo_q[i] <= '0;
    end else begin
      if (push) begin
        fifo_q[tail_q] <= owner_q;
        tail_q         <= ptr_inc(tail_q);
      end
      if (pop) head_q <= ptr_inc(head_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if ((rx_started || rx_done) && !rx_ok) rx_orphan <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table plus reply-routing scoreboard
// for a 2-client fixed-priority and a 3-client round-robin arbiter.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] req_valid, req_reply_wanted, req_reserve;
  logic [5:0] req_command;
  logic [3:0] req_data;
  logic [1:0] grant;
  logic [1:0] c_tx_command_started, c_tx_active, c_tx_data_next, c_tx_done;
  logic [1:0] c_rx_started, c_rx_active, c_rx_sbs_valid;
  logic [1:0] c_rx_data_valid, c_rx_done;
  logic       tx_command_valid;
  logic [2:0] tx_command;
  logic [1:0] tx_data;
  logic tx_command_started, tx_active, tx_data_next, tx_done;
  logic rx_started, rx_active, rx_sbs_valid, rx_data_valid, rx_done;
  logic [2:0] outstanding;
  logic       full, rx_orphan;

  logic [2:0] r_req_valid, r_req_reply_wanted, r_req_reserve;
  logic [8:0] r_req_command;
  logic [5:0] r_req_data;
  logic [2:0] r_grant;
  logic [2:0] r_c_tx_command_started, r_c_tx_active;
  logic [2:0] r_c_tx_data_next, r_c_tx_done;
  logic [2:0] r_c_rx_started, r_c_rx_active, r_c_rx_sbs_valid;
  logic [2:0] r_c_rx_data_valid, r_c_rx_done;
  logic       r_tx_command_valid;
  logic [2:0] r_tx_command;
  logic [1:0] r_tx_data;
  logic r_tx_command_started, r_tx_active, r_tx_data_next, r_tx_done;
  logic r_rx_started, r_rx_active, r_rx_sbs_valid;
  logic r_rx_data_valid, r_rx_done;
  logic [2:0] r_outstanding;
  logic       r_full, r_rx_orphan;

  mem_port_arbiter #(
    .NCLIENTS(2), .IO_BITS(2), .CMD_BITS(3),
    .MAX_OUTSTANDING(7), .RR_MODE(0)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_command(req_command),
    .req_data(req_data), .req_reply_wanted(req_reply_wanted),
    .req_reserve(req_reserve), .grant(grant),
    .c_tx_command_started(c_tx_command_started),
    .c_tx_active(c_tx_active), .c_tx_data_next(c_tx_data_next),
    .c_tx_done(c_tx_done), .c_rx_started(c_rx_started),
    .c_rx_active(c_rx_active), .c_rx_sbs_valid(c_rx_sbs_valid),
    .c_rx_data_valid(c_rx_data_valid), .c_rx_done(c_rx_done),
    .tx_command_valid(tx_command_valid), .tx_command(tx_command),
    .tx_data(tx_data), .tx_command_started(tx_command_started),
    .tx_active(tx_active), .tx_data_next(tx_data_next),
    .tx_done(tx_done), .rx_started(rx_started),
    .rx_active(rx_active), .rx_sbs_valid(rx_sbs_valid),
    .rx_data_valid(rx_data_valid), .rx_done(rx_done),
    .outstanding(outstanding), .full(full), .rx_orphan(rx_orphan)
  );

  mem_port_arbiter #(
    .NCLIENTS(3), .IO_BITS(2), .CMD_BITS(3),
    .MAX_OUTSTANDING(7), .RR_MODE(1)
  ) dut_rr (
    .clk(clk), .reset(reset),
    .req_valid(r_req_valid), .req_command(r_req_command),
    .req_data(r_req_data), .req_reply_wanted(r_req_reply_wanted),
    .req_reserve(r_req_reserve), .grant(r_grant),
    .c_tx_command_started(r_c_tx_command_started),
    .c_tx_active(r_c_tx_active), .c_tx_data_next(r_c_tx_data_next),
    .c_tx_done(r_c_tx_done), .c_rx_started(r_c_rx_started),
    .c_rx_active(r_c_rx_active), .c_rx_sbs_valid(r_c_rx_sbs_valid),
    .c_rx_data_valid(r_c_rx_data_valid), .c_rx_done(r_c_rx_done),
    .tx_command_valid(r_tx_command_valid), .tx_command(r_tx_command),
    .tx_data(r_tx_data), .tx_command_started(r_tx_command_started),
    .tx_active(r_tx_active), .tx_data_next(r_tx_data_next),
    .tx_done(r_tx_done), .rx_started(r_rx_started),
    .rx_active(r_rx_active), .rx_sbs_valid(r_rx_sbs_valid),
    .rx_data_valid(r_rx_data_valid), .rx_done(r_rx_done),
    .outstanding(r_outstanding), .full(r_full),
    .rx_orphan(r_rx_orphan)
  );

  typedef struct {
    logic [1:0] rv;
    logic [1:0] res;
    logic       stb;
    logic [1:0] g;
    logic       v;
    logic [2:0] cmd;
    logic [1:0] dat;
    logic [1:0] cstb;
  } vec_t;

  vec_t tbl [10];
  int   exp_q [$];
  int   errors = 0;
  int   checks = 0;
  bit   orphan_exp = 1'b0;

  function automatic logic [31:0] oh(input int i);
    return 32'd1 << i;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input logic [1:0] rv, input logic [1:0] res,
                         input int who, input bit reply);
    tick();
    req_valid        = rv;
    req_reserve      = res;
    req_reply_wanted = reply ? 2'b11 : 2'b00;
    @(negedge clk);
    chk("txn_grant", 32'(grant), oh(who));
    tick();
    tx_command_started = 1'b1;
    tx_active          = 1'b1;
    @(negedge clk);
    chk("txn_started", 32'(c_tx_command_started), oh(who));
    if (reply) exp_q.push_back(who);
    tick();
    tx_command_started = 1'b0;
    tx_done            = 1'b1;
    @(negedge clk);
    chk("txn_outstanding", 32'(outstanding), 32'(exp_q.size()));
    tick();
    tx_done   = 1'b0;
    tx_active = 1'b0;
  endtask

  task automatic rx_resp();
    int  who;
    int  dummy;
    bit  have;
    have = (exp_q.size() != 0);
    who  = have ? exp_q[0] : 0;
    tick();
    rx_started = 1'b1;
    rx_active  = 1'b1;
    @(negedge clk);
    chk("rx_started", 32'(c_rx_started), have ? oh(who) : 32'd0);
    tick();
    rx_started    = 1'b0;
    rx_data_valid = 1'b1;
    rx_done       = 1'b1;
    @(negedge clk);
    chk("rx_done", 32'(c_rx_done), have ? oh(who) : 32'd0);
    if (have) dummy = exp_q.pop_front();
    else orphan_exp = 1'b1;
    tick();
    rx_done       = 1'b0;
    rx_data_valid = 1'b0;
    rx_active     = 1'b0;
    @(negedge clk);
    chk("rx_outstanding", 32'(outstanding), 32'(exp_q.size()));
    chk("rx_orphan", 32'(rx_orphan), 32'(orphan_exp));
  endtask

  task automatic rr_txn(input logic [2:0] exp_g);
    tick();
    @(negedge clk);
    chk("rr_grant", 32'(r_grant), 32'(exp_g));
    tick();
    r_tx_command_started = 1'b1;
    r_tx_active          = 1'b1;
    tick();
    r_tx_command_started = 1'b0;
    r_tx_done            = 1'b1;
    tick();
    r_tx_done   = 1'b0;
    r_tx_active = 1'b0;
  endtask

  initial begin
    req_valid = '0; req_reply_wanted = '0; req_reserve = '0;
    req_command = {3'b011, 3'b101};
    req_data    = {2'b10, 2'b01};
    tx_command_started = 0; tx_active = 0; tx_data_next = 0;
    tx_done = 0; rx_started = 0; rx_active = 0; rx_sbs_valid = 0;
    rx_data_valid = 0; rx_done = 0;
    r_req_valid = '0; r_req_reply_wanted = '0; r_req_reserve = '0;
    r_req_command = {3'b110, 3'b010, 3'b001};
    r_req_data    = {2'b11, 2'b10, 2'b01};
    r_tx_command_started = 0; r_tx_active = 0; r_tx_data_next = 0;
    r_tx_done = 0; r_rx_started = 0; r_rx_active = 0;
    r_rx_sbs_valid = 0; r_rx_data_valid = 0; r_rx_done = 0;

    tbl[0] = '{2'b00, 2'b00, 1'b0, 2'b01, 1'b0, 3'b101, 2'b01, 2'b00};
    tbl[1] = '{2'b01, 2'b00, 1'b1, 2'b01, 1'b1, 3'b101, 2'b01, 2'b01};
    tbl[2] = '{2'b11, 2'b00, 1'b1, 2'b10, 1'b1, 3'b011, 2'b10, 2'b10};
    tbl[3] = '{2'b00, 2'b00, 1'b0, 2'b10, 1'b0, 3'b011, 2'b10, 2'b00};
    tbl[4] = '{2'b10, 2'b00, 1'b1, 2'b10, 1'b1, 3'b011, 2'b10, 2'b10};
    tbl[5] = '{2'b01, 2'b00, 1'b0, 2'b01, 1'b1, 3'b101, 2'b01, 2'b00};
    tbl[6] = '{2'b00, 2'b10, 1'b1, 2'b10, 1'b0, 3'b011, 2'b10, 2'b10};
    tbl[7] = '{2'b01, 2'b10, 1'b0, 2'b10, 1'b0, 3'b011, 2'b10, 2'b00};
    tbl[8] = '{2'b11, 2'b00, 1'b1, 2'b10, 1'b1, 3'b011, 2'b10, 2'b10};
    tbl[9] = '{2'b00, 2'b01, 1'b0, 2'b01, 1'b0, 3'b101, 2'b01, 2'b00};

    #2;
    chk("rst_outstanding", 32'(outstanding), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_orphan", 32'(rx_orphan), 32'd0);
    chk("rst_grant", 32'(grant), 32'd1);
    chk("rst_rr_grant", 32'(r_grant), 32'd1);
    tick();
    reset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      tick();
      req_valid    = tbl[i].rv;
      req_reserve  = tbl[i].res;
      tx_data_next = tbl[i].stb;
      @(negedge clk);
      chk("vec_grant", 32'(grant), 32'(tbl[i].g));
      chk("vec_valid", 32'(tx_command_valid), 32'(tbl[i].v));
      chk("vec_cmd", 32'(tx_command), 32'(tbl[i].cmd));
      chk("vec_data", 32'(tx_data), 32'(tbl[i].dat));
      chk("vec_strobe", 32'(c_tx_data_next), 32'(tbl[i].cstb));
    end
    tx_data_next = 1'b0;
    req_reserve  = '0;

    // fixed priority: client1 keeps the port until its tx_done
    tick();
    req_valid = 2'b11;
    @(negedge clk);
    chk("fp_both", 32'(grant), 32'd2);
    tick();
    req_valid = 2'b01;
    tx_command_started = 1'b1;
    tx_active = 1'b1;
    @(negedge clk);
    chk("fp_hold", 32'(grant), 32'd2);
    tick();
    tx_command_started = 1'b0;
    tx_done = 1'b1;
    @(negedge clk);
    chk("fp_hold_done", 32'(grant), 32'd2);
    tick();
    tx_done = 1'b0;
    tx_active = 1'b0;
    @(negedge clk);
    chk("fp_next", 32'(grant), 32'd1);

    // replies return in issue order
    run_txn(2'b10, 2'b00, 1, 1'b1);
    run_txn(2'b01, 2'b00, 0, 1'b1);
    rx_resp();
    rx_resp();

    // reply with nothing outstanding
    rx_resp();

    // reservation
    run_txn(2'b01, 2'b01, 0, 1'b0);
    run_txn(2'b11, 2'b01, 0, 1'b0);
    tick();
    req_valid   = 2'b10;
    req_reserve = 2'b00;
    @(negedge clk);
    chk("res_still", 32'(grant), 32'd1);
    tick();
    @(negedge clk);
    chk("res_drop", 32'(grant), 32'd2);

    // fill the tag FIFO, then wrap it
    for (int k = 0; k < 7; k++) begin
      if (k % 2 == 0) run_txn(2'b10, 2'b00, 1, 1'b1);
      else run_txn(2'b01, 2'b00, 0, 1'b1);
    end
    tick();
    req_valid = 2'b10;
    @(negedge clk);
    chk("full_set", 32'(full), 32'd1);
    chk("full_valid", 32'(tx_command_valid), 32'd0);
    rx_resp();
    chk("full_clr", 32'(full), 32'd0);
    chk("full_clr_valid", 32'(tx_command_valid), 32'd1);
    run_txn(2'b01, 2'b00, 0, 1'b1);
    for (int k = 0; k < 7; k++) rx_resp();

    // reset in the middle of a transaction
    run_txn(2'b10, 2'b00, 1, 1'b1);
    run_txn(2'b10, 2'b00, 1, 1'b1);
    tick();
    tx_command_started = 1'b1;
    tx_active = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_outstanding", 32'(outstanding), 32'd0);
    chk("mid_rst_orphan", 32'(rx_orphan), 32'd0);
    chk("mid_rst_strobe", 32'(c_tx_active), 32'd0);
    exp_q.delete();
    orphan_exp = 1'b0;
    tx_command_started = 1'b0;
    tx_active = 1'b0;
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_strobe", 32'(c_tx_command_started), 32'd0);
    chk("post_rst_outstanding", 32'(outstanding), 32'd0);
    chk("post_rst_grant", 32'(grant), 32'd2);

    // round-robin
    r_req_valid = 3'b111;
    rr_txn(3'b001);
    rr_txn(3'b010);
    rr_txn(3'b100);
    rr_txn(3'b001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
N-client arbiter between instruction/data requesters and the single serial memory_interface. It generalises the CPU-level prefetcher/scheduler TX mux and transaction-type FIFO to NCLIENTS requesters, with:
- selectable fixed-priority or round-robin arbitration;
- per-client TX reservation;
- a tag FIFO that routes each RX response back to the client that issued the read.

It sits between the clients (prefetcher, decoder/scheduler, future DMA) and memory_interface.

Parameters:
NCLIENTS, 2, number of requesting clients (>=2).
IO_BITS, 2, width of the TX/RX data nibble.
CMD_BITS, 3, TX command header width.
MAX_OUTSTANDING, 7, tag FIFO depth (max reads awaiting reply).
RR_MODE, 0, 0 = fixed priority (highest index wins), 1 = round-robin.
TAG_BITS, max(1,$clog2(NCLIENTS)), client-index width (derived).

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
req_valid  in  NCLIENTS  client has a command ready
req_command  in  NCLIENTS*CMD_BITS  packed per-client command, client i at [i*CMD_BITS +: CMD_BITS]
req_data  in  NCLIENTS*IO_BITS  packed per-client TX payload nibble
req_reply_wanted  in  NCLIENTS  command will produce an RX response
req_reserve  in  NCLIENTS  keep TX ownership after current transaction
grant  out  NCLIENTS  one-hot current TX owner
c_tx_command_started, c_tx_active, c_tx_data_next, c_tx_done  out  NCLIENTS each  memory-interface TX strobes gated by grant
c_rx_started, c_rx_active, c_rx_sbs_valid, c_rx_data_valid, c_rx_done  out  NCLIENTS each  RX strobes gated by rx owner
tx_command_valid  out  1  to memory_interface
tx_command  out  CMD_BITS  to memory_interface
tx_data  out  IO_BITS  to memory_interface
tx_command_started, tx_active, tx_data_next, tx_done  in  1 each  from memory_interface
rx_started, rx_active, rx_sbs_valid, rx_data_valid, rx_done  in  1 each  from memory_interface
outstanding  out  $clog2(MAX_OUTSTANDING+1)  reads awaiting reply
full  out  1  outstanding == MAX_OUTSTANDING
rx_orphan  out  1  sticky: rx_started seen while FIFO empty

Behaviour:
- Reset (async, reset=0):
  - owner_q=0, rr_ptr=0, reserved_q=0;
  - FIFO head, tail and count cleared;
  - rx_orphan=0;
  - all gated strobes 0; grant reflects idle arbitration of current inputs.
- Arbitration (combinational when !tx_active and !reserved_q):
  - RR_MODE=0: highest-index client with req_valid|req_reserve wins.
  - RR_MODE=1: first such client at or after rr_ptr, circularly.
  - No requester: grant = owner_q.
- Ownership:
  - grant = (tx_active || reserved_q) ? onehot(owner_q) : onehot(arb).
  - owner_q <= winner every cycle while !tx_active && !reserved_q.
- Reservation: on tx_done, reserved_q <= req_reserve[owner_q]. While reserved_q=1, other clients are ignored. Dropping req_reserve while idle-reserved clears reserved_q next cycle.
- Round-robin pointer: rr_ptr <= owner_q+1 (mod NCLIENTS) on tx_done when req_reserve[owner_q]=0.
- TX mux:
  - tx_command, tx_data = selected client's slice;
  - tx_command_valid = req_valid[grant] && !full;
  - gated TX strobes = input strobe & grant bit.
- Tag FIFO:
  - push owner_q index on tx_command_started && req_reply_wanted[owner];
  - pop on rx_done;
  - head entry is the RX owner; RX strobes are routed to it only while the FIFO is non-empty;
  - simultaneous push+pop leaves count unchanged (push while full impossible because valid is gated);
  - pointers wrap at MAX_OUTSTANDING (non-power-of-2 depth supported);
  - pop while empty is ignored and sets rx_orphan.
- Latency: grant-to-tx_command_valid 0 cycles; push visible in outstanding the next cycle.
- Mid-transaction reset aborts all state; a client strobe must not assert in the cycle after reset release unless its input strobe is high.

Test Plan:
- NCLIENTS=2, RR_MODE=0, both req_valid -> grant=2'b10; client0 granted only after client1 tx_done with req_valid[1]=0.
- NCLIENTS=3, RR_MODE=1, all requesting, 3 transactions -> grants in order 2'b001, 3'b010, 3'b100, then 3'b001 again.
- Client1 issues reply read, client0 issues reply read, two responses -> first c_rx_done[1], then c_rx_done[0]; outstanding goes 1,2,1,0.
- Issue 7 reply reads without rx_done -> full=1, tx_command_valid=0 despite req_valid; one rx_done -> full=0 next cycle.
- Client0 holds req_reserve across tx_done while client1 requests -> grant stays on client0 for two transactions; drop reserve -> client1 granted.
- rx_done with empty FIFO -> rx_orphan=1, no c_rx_* strobe; reset low mid-TX -> outstanding=0 and rx_orphan=0 immediately.
